// File: rtl/wash_cycle_sequencer.sv
// wash_cycle_sequencer
// Washing-machine cycle controller and the initiating end of the Timer link.
// A coin starts a FILL -> WASH -> RINSE -> SPIN walk. An optional second
// WASH+RINSE pass runs if Double_Wash was high when the coin was accepted.
// Each phase drives a duration code to the Timer and advances on Time_Event.
// Optional feature macro: ABORT_EN adds an Abort input that returns any
// running phase to IDLE on the next edge.
module wash_cycle_sequencer #(
    parameter logic [2:0] ENC_FILL  = 3'b000,
    parameter logic [2:0] ENC_WASH  = 3'b001,
    parameter logic [2:0] ENC_RINSE = 3'b010,
    parameter logic [2:0] ENC_SPIN  = 3'b011,
    parameter logic [2:0] ENC_IDLE  = 3'b111
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Coin_In,
    input  logic       Double_Wash,
    input  logic       Timer_Pause,
    input  logic       Time_Event,
`ifdef ABORT_EN
    input  logic       Abort,
`endif
    output logic [2:0] Timer_Encoding,
    output logic       Pause_Enable_T,
    output logic       Timer_Restart,
    output logic [2:0] Phase,
    output logic       Wash_Done
);

    // State encoding doubles as the Phase code reported to the panel.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WASH  = 3'd2,
        ST_RINSE = 3'd3,
        ST_SPIN  = 3'd4
    } state_t;

    state_t state_r;
    logic   dbl_flag_r;
    logic   second_pass_r;
    logic   abort_s;
    logic   event_s;

`ifdef ABORT_EN
    assign abort_s = Abort;
`else
    assign abort_s = 1'b0;
`endif

    // A Timer expiry only counts while the Timer is not frozen.
    assign event_s = Time_Event & ~Pause_Enable_T;

    // Phase is the state register itself, so it is registered by construction.
    assign Phase = state_r;

    // Phase sequencer: state, pass flags and all registered Timer/panel outputs.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r        <= ST_IDLE;
            Timer_Encoding <= ENC_IDLE;
            Pause_Enable_T <= 1'b0;
            Timer_Restart  <= 1'b0;
            Wash_Done      <= 1'b0;
            dbl_flag_r     <= 1'b0;
            second_pass_r  <= 1'b0;
        end else begin
            // Pulses default low; pause is only ever held while staying in SPIN.
            Timer_Restart  <= 1'b0;
            Wash_Done      <= 1'b0;
            Pause_Enable_T <= 1'b0;
            if (abort_s && (state_r != ST_IDLE)) begin
                state_r        <= ST_IDLE;
                Timer_Encoding <= ENC_IDLE;
                dbl_flag_r     <= 1'b0;
                second_pass_r  <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (Coin_In && !abort_s) begin
                            state_r        <= ST_FILL;
                            Timer_Encoding <= ENC_FILL;
                            Timer_Restart  <= 1'b1;
                            dbl_flag_r     <= Double_Wash;
                        end
                    end
                    ST_FILL: begin
                        if (event_s) begin
                            state_r        <= ST_WASH;
                            Timer_Encoding <= ENC_WASH;
                            Timer_Restart  <= 1'b1;
                        end
                    end
                    ST_WASH: begin
                        if (event_s) begin
                            state_r        <= ST_RINSE;
                            Timer_Encoding <= ENC_RINSE;
                            Timer_Restart  <= 1'b1;
                        end
                    end
                    ST_RINSE: begin
                        if (event_s) begin
                            if (dbl_flag_r && !second_pass_r) begin
                                state_r        <= ST_WASH;
                                Timer_Encoding <= ENC_WASH;
                                second_pass_r  <= 1'b1;
                            end else begin
                                state_r        <= ST_SPIN;
                                Timer_Encoding <= ENC_SPIN;
                            end
                            Timer_Restart <= 1'b1;
                        end
                    end
                    ST_SPIN: begin
                        if (event_s) begin
                            state_r        <= ST_IDLE;
                            Timer_Encoding <= ENC_IDLE;
                            Wash_Done      <= 1'b1;
                            dbl_flag_r     <= 1'b0;
                            second_pass_r  <= 1'b0;
                        end else begin
                            Pause_Enable_T <= Timer_Pause;
                        end
                    end
                    default: begin
                        state_r        <= ST_IDLE;
                        Timer_Encoding <= ENC_IDLE;
                        dbl_flag_r     <= 1'b0;
                        second_pass_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// tb_wash_cycle_sequencer
// Directed bench for wash_cycle_sequencer. A phase-level model (phase number,
// pass flags, expected pause) is stepped every clock and compared with the DUT.
// Literal expectations per scenario pin the model itself.
`timescale 1ns/1ps
module tb_wash_cycle_sequencer;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Coin_In;
    logic       Double_Wash;
    logic       Timer_Pause;
    logic       Time_Event;
`ifdef ABORT_EN
    logic       Abort;
`endif
    logic [2:0] Timer_Encoding;
    logic       Pause_Enable_T;
    logic       Timer_Restart;
    logic [2:0] Phase;
    logic       Wash_Done;

    wash_cycle_sequencer dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Coin_In        (Coin_In),
        .Double_Wash    (Double_Wash),
        .Timer_Pause    (Timer_Pause),
        .Time_Event     (Time_Event),
`ifdef ABORT_EN
        .Abort          (Abort),
`endif
        .Timer_Encoding (Timer_Encoding),
        .Pause_Enable_T (Pause_Enable_T),
        .Timer_Restart  (Timer_Restart),
        .Phase          (Phase),
        .Wash_Done      (Wash_Done)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: phase number 0..4 and the flags the rules talk about.
    int m_phase;
    bit m_dbl, m_second, m_pause, m_restart, m_done;

    // Observation of the DUT for per-scenario literal checks.
    int rst_cnt, done_cnt, last_ph, last_enc;
    int ph_q[$];
    int enc_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_q(input string nm, input int got[$], input int exp[$]);
        chk({nm, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk(nm, got[i], exp[i]);
    endtask

    task automatic model_reset();
        m_phase = 0; m_dbl = 0; m_second = 0;
        m_pause = 0; m_restart = 0; m_done = 0;
    endtask

    task automatic model_step();
        int prev;
        int nxt;
        bit ev;
        bit ab;
        if (!Rst) begin
            model_reset();
            return;
        end
        ab = 1'b0;
`ifdef ABORT_EN
        ab = Abort;
`endif
        prev   = m_phase;
        nxt    = m_phase;
        m_done = 0;
        ev     = Time_Event && !m_pause;
        if (ab && prev != 0) begin
            nxt = 0; m_dbl = 0; m_second = 0;
        end else if (prev == 0) begin
            if (Coin_In && !ab) begin
                nxt = 1; m_dbl = Double_Wash;
            end
        end else if (ev) begin
            if (prev == 3 && m_dbl && !m_second) begin
                nxt = 2; m_second = 1;
            end else if (prev == 4) begin
                nxt = 0; m_done = 1; m_dbl = 0; m_second = 0;
            end else begin
                nxt = prev + 1;
            end
        end
        m_pause   = (prev == 4 && nxt == 4) ? Timer_Pause : 1'b0;
        m_restart = (nxt != prev) && (nxt != 0);
        m_phase   = nxt;
    endtask

    task automatic compare_model();
        int exp_enc;
        exp_enc = (m_phase == 0) ? 7 : m_phase - 1;
        chk("phase", 32'(Phase), m_phase);
        chk("encoding", 32'(Timer_Encoding), exp_enc);
        chk("pause_en", 32'(Pause_Enable_T), 32'(m_pause));
        chk("restart", 32'(Timer_Restart), 32'(m_restart));
        chk("wash_done", 32'(Wash_Done), 32'(m_done));
    endtask

    task automatic start_trace();
        rst_cnt = 0; done_cnt = 0;
        ph_q.delete(); enc_q.delete();
        last_ph = int'(Phase); last_enc = int'(Timer_Encoding);
    endtask

    // One clock: model steps on the edge, DUT compared 1 ns later, return at negedge.
    task automatic cycle();
        @(posedge Clk);
        model_step();
        #1;
        compare_model();
        if (Timer_Restart === 1'b1) rst_cnt++;
        if (Wash_Done === 1'b1) done_cnt++;
        if (int'(Phase) != last_ph) begin ph_q.push_back(int'(Phase)); last_ph = int'(Phase); end
        if (int'(Timer_Encoding) != last_enc) begin
            enc_q.push_back(int'(Timer_Encoding)); last_enc = int'(Timer_Encoding);
        end
        @(negedge Clk);
    endtask

    task automatic pulse_te();
        Time_Event = 1'b1;
        cycle();
        Time_Event = 1'b0;
        cycle();
    endtask

    initial begin
        int e[$];
        Rst = 1'b0; Coin_In = 1'b0; Double_Wash = 1'b0;
        Timer_Pause = 1'b0; Time_Event = 1'b0;
`ifdef ABORT_EN
        Abort = 1'b0;
`endif
        model_reset();
        cycle();
        cycle();
        Rst = 1'b1;
        cycle();
        chk("reset_phase", 32'(Phase), 0);
        chk("reset_enc", 32'(Timer_Encoding), 7);
        chk("reset_pause", 32'(Pause_Enable_T), 0);

        // Time_Event while idle does nothing.
        Time_Event = 1'b1;
        cycle();
        Time_Event = 1'b0;
        chk("idle_te_phase", 32'(Phase), 0);
        chk("idle_te_restart", 32'(Timer_Restart), 0);

        // Single wash.
        start_trace();
        Coin_In = 1'b1;
        cycle();
        Coin_In = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            pulse_te();
        end
        cycle();
        e = '{1, 2, 3, 4, 0};
        check_q("single_phase_seq", ph_q, e);
        e = '{0, 1, 2, 3, 7};
        check_q("single_enc_seq", enc_q, e);
        chk("single_restarts", rst_cnt, 4);
        chk("single_done", done_cnt, 1);

        // Double wash; Double_Wash dropped right after acceptance.
        start_trace();
        Coin_In = 1'b1; Double_Wash = 1'b1;
        cycle();
        Coin_In = 1'b0; Double_Wash = 1'b0;
        for (int i = 0; i < 6; i++) pulse_te();
        cycle();
        e = '{1, 2, 3, 2, 3, 4, 0};
        check_q("double_phase_seq", ph_q, e);
        chk("double_restarts", rst_cnt, 6);
        chk("double_done", done_cnt, 1);

        // Pause in SPIN freezes the phase.
        start_trace();
        Coin_In = 1'b1;
        cycle();
        Coin_In = 1'b0;
        for (int i = 0; i < 3; i++) pulse_te();
        chk("pause_at_spin", 32'(Phase), 4);
        Timer_Pause = 1'b1;
        cycle();
        chk("pause_set", 32'(Pause_Enable_T), 1);
        Time_Event = 1'b1;
        cycle();
        Time_Event = 1'b0;
        chk("pause_hold_phase", 32'(Phase), 4);
        Timer_Pause = 1'b0;
        cycle();
        chk("pause_release", 32'(Pause_Enable_T), 0);
        Time_Event = 1'b1;
        cycle();
        Time_Event = 1'b0;
        chk("pause_done", 32'(Wash_Done), 1);
        chk("pause_end_phase", 32'(Phase), 0);
        cycle();

        // Pause outside SPIN is ignored.
        Coin_In = 1'b1;
        cycle();
        Coin_In = 1'b0;
        pulse_te();
        Timer_Pause = 1'b1;
        cycle();
        chk("wash_pause_off", 32'(Pause_Enable_T), 0);
        Time_Event = 1'b1;
        cycle();
        Time_Event = 1'b0;
        chk("wash_pause_adv", 32'(Phase), 3);
        Timer_Pause = 1'b0;
        pulse_te();
        pulse_te();

        // Coin held through SPIN; Time_Event and pause rising together in SPIN.
        start_trace();
        Coin_In = 1'b1;
        cycle();
        for (int i = 0; i < 3; i++) pulse_te();
        chk("held_at_spin", 32'(Phase), 4);
        Time_Event = 1'b1; Timer_Pause = 1'b1;
        cycle();
        Time_Event = 1'b0; Timer_Pause = 1'b0;
        chk("race_phase", 32'(Phase), 0);
        chk("race_pause", 32'(Pause_Enable_T), 0);
        chk("race_done", 32'(Wash_Done), 1);
        cycle();
        chk("held_restart_phase", 32'(Phase), 1);
        chk("held_restart_pulse", 32'(Timer_Restart), 1);
        Coin_In = 1'b0;
        for (int i = 0; i < 4; i++) pulse_te();

        // Reset in the middle of RINSE.
        start_trace();
        Coin_In = 1'b1;
        cycle();
        Coin_In = 1'b0;
        pulse_te();
        pulse_te();
        chk("mid_rinse", 32'(Phase), 3);
        #2;
        Rst = 1'b0;
        #0.01;
        model_reset();
        chk("mid_rst_phase", 32'(Phase), 0);
        chk("mid_rst_enc", 32'(Timer_Encoding), 7);
        chk("mid_rst_pause", 32'(Pause_Enable_T), 0);
        chk("mid_rst_done", 32'(Wash_Done), 0);
        #0.01;
        Rst = 1'b1;
        Coin_In = 1'b1;
        cycle();
        Coin_In = 1'b0;
        chk("after_rst_fill", 32'(Phase), 1);
        chk("after_rst_no_done", done_cnt, 0);
        for (int i = 0; i < 4; i++) pulse_te();

`ifdef ABORT_EN
        // Abort during WASH beats a simultaneous Time_Event.
        Coin_In = 1'b1;
        cycle();
        Coin_In = 1'b0;
        pulse_te();
        Abort = 1'b1; Time_Event = 1'b1;
        cycle();
        Time_Event = 1'b0;
        chk("abort_phase", 32'(Phase), 0);
        chk("abort_enc", 32'(Timer_Encoding), 7);
        chk("abort_restart", 32'(Timer_Restart), 0);
        chk("abort_done", 32'(Wash_Done), 0);
        Coin_In = 1'b1;
        cycle();
        chk("abort_blocks_coin", 32'(Phase), 0);
        Abort = 1'b0; Coin_In = 1'b0;
        cycle();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
